tx_packet_sequencer: RTL and testbench
======================================

TX_PACKET_SEQUENCER -- requirements
Module: tx_packet_sequencer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-002 Parameter FIFO_DEPTH, default 8: sample buffer entries; power of 2, 2..16.
REQ-003 Parameter ACK_TIMEOUT_CYC, default 15: max cycles to wait for TX_BUSY rise after TX_START.
REQ-004 CLOCK  in  1  single block clock; all logic on rising edge.
REQ-005 RESET_N  in  1  asynchronous active-low reset.
REQ-006 IN_VALID  in  1  beamformer sample valid.
REQ-007 IN_DATA  in  16  beamformer output sample.
REQ-008 IN_READY  out  1  buffer can accept a sample.
REQ-009 TX_BUSY  in  1  registered busy flag from the UART communication stage.
REQ-010 TX_START  out  1  one-cycle request to the UART stage to send TX_DATA.
REQ-011 TX_DATA  out  8  byte to transmit; drives the UART stage data input.
REQ-012 FIFO_LEVEL  out  5  buffered sample count.
REQ-013 OVERFLOW  out  1  sticky: a sample was offered while full.
REQ-014 ACK_TIMEOUT  out  1  sticky: UART stage failed to go busy after TX_START.
REQ-015 IDLE  out  1  high in IDLE state with empty buffer.

Function
REQ-016 Sample accepted on a rising edge with IN_VALID=1 and IN_READY=1; IN_READY = (FIFO_LEVEL < FIFO_DEPTH).
REQ-017 IN_VALID=1 while full: sample dropped, OVERFLOW set next cycle, buffer contents unchanged.
REQ-018 Push and pop in the same cycle: both happen, FIFO_LEVEL unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-019 Each sample is sent as one frame: SYNC_BYTE, IN_DATA[15:8], IN_DATA[7:0] (plus checksum per REQ-031), in that order, with no interleaving between frames.
REQ-020 States: IDLE, LOAD, SEND, WAIT_HI, WAIT_LO.
REQ-021 IDLE -> LOAD when FIFO_LEVEL != 0 and TX_BUSY=0.
REQ-022 LOAD: pop the head sample into a 16-bit frame register, byte index := 0; -> SEND next cycle.
REQ-023 SEND: TX_DATA = byte[index], TX_START=1 for exactly this cycle; -> WAIT_HI.
REQ-024 TX_DATA is held stable from SEND until the exit from WAIT_LO.
REQ-025 WAIT_HI: wait for TX_BUSY=1, then -> WAIT_LO; after ACK_TIMEOUT_CYC cycles without it, set ACK_TIMEOUT and treat the byte as sent (go to the WAIT_LO exit decision).
REQ-026 WAIT_LO: wait for TX_BUSY=0; then if index is the last byte -> IDLE, else index+1 -> SEND.
REQ-027 First TX_START of a frame occurs 2 cycles after the IDLE->LOAD decision; the bytes of one frame are never closer than a full UART busy period.
REQ-028 TX_START is never asserted while TX_BUSY=1.
REQ-029 Samples arriving mid-frame are buffered; they do not disturb the current frame.

Reset
REQ-030 RESET_N low, at any time including mid-frame: state IDLE, FIFO emptied, index 0, TX_START=0, TX_DATA=8'h00, FIFO_LEVEL=0, IN_READY=1, OVERFLOW=0, ACK_TIMEOUT=0, IDLE=1. A partial frame is abandoned and not resumed.

Configuration
REQ-031 Macro TX_CHECKSUM_EN defined: the frame is 4 bytes, with a last byte of SYNC_BYTE ^ IN_DATA[15:8] ^ IN_DATA[7:0]. Undefined: the frame is 3 bytes, and there is no checksum logic.

Verification
REQ-032 Single sample 16'h1234, TX_BUSY modelled as high for 10 cycles starting 2 cycles after each TX_START -> TX_DATA A5,12,34 (plus 0x83 with TX_CHECKSUM_EN), one TX_START each, IDLE=1 afterwards.
REQ-033 Nine back-to-back samples with TX_BUSY stuck high -> the first 8 are accepted, then IN_READY=0, the ninth is dropped, OVERFLOW=1 and FIFO_LEVEL=8.
REQ-034 Push during a pop at FIFO_LEVEL=3 -> the level stays 3, and frames come out in FIFO order across pointer wrap (20 samples total).
REQ-035 TX_BUSY held at 0 after TX_START -> ACK_TIMEOUT=1 after 15 cycles, and the sequencer moves to the next byte.
REQ-036 RESET_N pulsed low during the second byte of a frame -> all outputs at reset values immediately, and no further bytes of that frame are sent after release.

Source files
------------

// File: rtl/tx_packet_sequencer.sv
// Buffers 16-bit beamformer samples and sends each one as a framed byte sequence to a UART stage.
// Optional build macro: TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
module tx_packet_sequencer #(
  parameter logic [7:0] SYNC_BYTE       = 8'hA5,
  parameter int         FIFO_DEPTH      = 8,
  parameter int         ACK_TIMEOUT_CYC = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  input  logic [15:0] i_in_data,
  output logic        o_in_ready,
  input  logic        i_tx_busy,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic [4:0]  o_fifo_level,
  output logic        o_overflow,
  output logic        o_ack_timeout,
  output logic        o_idle
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (ACK_TIMEOUT_CYC > 1) ? $clog2(ACK_TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT_CYC - 1);
`ifdef TX_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } state_t;

  state_t          r_state;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [4:0]      r_level;
  logic [15:0]     r_frame;
  logic [1:0]      r_idx;
  logic [TW-1:0]   r_tmo_cnt;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic            r_overflow;
  logic            r_ack_timeout;

  logic            w_full;
  logic            w_push;
  logic            w_pop;

`ifdef TX_CHECKSUM_EN
  function automatic logic [7:0] f_checksum(input logic [15:0] frame);
    return SYNC_BYTE ^ frame[15:8] ^ frame[7:0];
  endfunction
`endif

  function automatic logic [7:0] f_frame_byte(input logic [15:0] frame, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = frame[15:8];
      2'd2:    b = frame[7:0];
`ifdef TX_CHECKSUM_EN
      2'd3:    b = f_checksum(frame);
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_full = (r_level == 5'(FIFO_DEPTH));
  assign w_push = i_in_valid && !w_full;
  // Only the LOAD state pops, and it is entered only with a non-empty buffer.
  assign w_pop  = (r_state == ST_LOAD);

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  // Buffer pointers, fill level and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
      if (i_in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Frame sequencing FSM with registered UART handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_frame       <= 16'h0000;
      r_idx         <= 2'd0;
      r_tmo_cnt     <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_ack_timeout <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if ((r_level != 5'd0) && !i_tx_busy) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_frame    <= r_mem[r_rd_ptr];
          r_idx      <= 2'd0;
          r_tx_data  <= SYNC_BYTE;
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_tmo_cnt <= '0;
          r_state   <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          // A missing busy acknowledge counts the byte as sent.
          if (i_tx_busy) begin
            r_state <= ST_WAIT_LO;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_ack_timeout <= 1'b1;
            r_state       <= ST_WAIT_LO;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!i_tx_busy) begin
            if (r_idx == LAST_IDX) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_tx_data  <= f_frame_byte(r_frame, r_idx + 2'd1);
              r_tx_start <= 1'b1;
              r_state    <= ST_SEND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready    = (r_level < 5'(FIFO_DEPTH));
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_fifo_level  = r_level;
  assign o_overflow    = r_overflow;
  assign o_ack_timeout = r_ack_timeout;
  assign o_idle        = (r_state == ST_IDLE) && (r_level == 5'd0);

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Directed bench for tx_packet_sequencer: vector table for buffer fill plus hand-written frame sequences.
module tb_tx_packet_sequencer;

`ifdef TX_CHECKSUM_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif
  localparam int M_AUTO = 0;
  localparam int M_HI   = 1;
  localparam int M_LO   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic [15:0] i_in_data = 16'h0000;
  logic        i_tx_busy = 1'b0;
  logic        o_in_ready, o_tx_start, o_overflow, o_ack_timeout, o_idle;
  logic [7:0]  o_tx_data;
  logic [4:0]  o_fifo_level;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int mode = M_HI;
  int st = 0;
  int en = 0;
  int busy_err = 0;
  int stab_err = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] q[$];

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        exp_ready;
    logic [4:0]  exp_level;
    logic        exp_ovf;
  } vec_t;
  vec_t vt[10];

  tx_packet_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
    .o_in_ready(o_in_ready), .i_tx_busy(i_tx_busy), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .o_fifo_level(o_fifo_level), .o_overflow(o_overflow),
    .o_ack_timeout(o_ack_timeout), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART stage model: byte capture, busy generation, and handshake/stability monitors.
  always @(negedge clk) begin
    if (rst_n && o_tx_start) begin
      q.push_back(o_tx_data);
      if (i_tx_busy) busy_err = busy_err + 1;
      if (mode == M_AUTO) begin
        st = cyc + 2;
        en = cyc + 12;
      end
    end
    if (!rst_n) begin
      prev_data = 8'h00;
    end else begin
      if (!o_tx_start && (o_tx_data !== prev_data)) stab_err = stab_err + 1;
      prev_data = o_tx_data;
    end
    case (mode)
      M_HI:    i_tx_busy = 1'b1;
      M_LO:    i_tx_busy = 1'b0;
      default: i_tx_busy = (cyc >= st) && (cyc < en);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] exp_byte(input logic [15:0] s, input int b);
    case (b)
      0:       return 8'hA5;
      1:       return s[15:8];
      2:       return s[7:0];
      default: return 8'hA5 ^ s[15:8] ^ s[7:0];
    endcase
  endfunction

  task automatic do_reset(input int m);
    @(posedge clk);
    mode = m;
    @(negedge clk);
    rst_n = 1'b0;
    i_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push1(input logic [15:0] d);
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_data = d;
    @(negedge clk);
    i_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int nbytes, input int budget, input string name);
    int k = 0;
    while (k < budget && !((q.size() >= nbytes) && o_idle)) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, (q.size() >= nbytes) && o_idle}, 32'd1);
  endtask

  task automatic cmp_frames(input int base, input logic [15:0] smp[$], input string name);
    chk({name, "_count"}, q.size() - base, smp.size() * FL);
    for (int k = 0; k < smp.size(); k++) begin
      for (int b = 0; b < FL; b++) begin
        int idx = base + k * FL + b;
        logic [31:0] act = (idx < q.size()) ? {24'd0, q[idx]} : 32'hFFFF_FFFF;
        chk($sformatf("%s_f%0d_b%0d", name, k, b), act, {24'd0, exp_byte(smp[k], b)});
      end
    end
  endtask

  initial begin
    int base;
    int s;
    int k;
    logic [15:0] smp[$];

    for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 16'h1000 + 16'(i), (i < 7), 5'(i + 1), 1'b0};
    vt[8] = '{1'b1, 16'h1008, 1'b0, 5'd8, 1'b1};
    vt[9] = '{1'b0, 16'h0000, 1'b0, 5'd8, 1'b1};

    // Reset state
    @(negedge clk);
    chk("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, o_tx_data}, 32'h00);
    chk("rst_level", {27'd0, o_fifo_level}, 32'd0);
    chk("rst_ready", {31'd0, o_in_ready}, 32'd1);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    chk("rst_ack", {31'd0, o_ack_timeout}, 32'd0);
    chk("rst_idle", {31'd0, o_idle}, 32'd1);

    // Single sample frame and first-start latency
    do_reset(M_AUTO);
    base = q.size();
    i_in_valid = 1'b1;
    i_in_data = 16'h1234;
    @(negedge clk);
    i_in_valid = 1'b0;
    chk("s1_start_p1", {31'd0, o_tx_start}, 32'd0);
    chk("s1_idle_p1", {31'd0, o_idle}, 32'd0);
    chk("s1_level_p1", {27'd0, o_fifo_level}, 32'd1);
    @(negedge clk);
    chk("s1_start_p2", {31'd0, o_tx_start}, 32'd0);
    @(negedge clk);
    chk("s1_start_p3", {31'd0, o_tx_start}, 32'd1);
    chk("s1_data_p3", {24'd0, o_tx_data}, 32'hA5);
    @(negedge clk);
    chk("s1_start_p4", {31'd0, o_tx_start}, 32'd0);
    chk("s1_data_p4", {24'd0, o_tx_data}, 32'hA5);
    wait_done(base + FL, 200, "s1_done");
    smp = '{16'h1234};
    cmp_frames(base, smp, "s1");
    chk("s1_idle_end", {31'd0, o_idle}, 32'd1);

    // Fill to full with busy stuck high, ninth sample dropped
    do_reset(M_HI);
    base = q.size();
    for (int i = 0; i < 10; i++) begin
      i_in_valid = vt[i].valid;
      i_in_data = vt[i].data;
      @(negedge clk);
      chk($sformatf("fill%0d_ready", i), {31'd0, o_in_ready}, {31'd0, vt[i].exp_ready});
      chk($sformatf("fill%0d_level", i), {27'd0, o_fifo_level}, {27'd0, vt[i].exp_level});
      chk($sformatf("fill%0d_ovf", i), {31'd0, o_overflow}, {31'd0, vt[i].exp_ovf});
    end
    i_in_valid = 1'b0;
    chk("fill_no_start", q.size() - base, 32'd0);
    @(posedge clk);
    mode = M_AUTO;
    wait_done(base + 8 * FL, 2000, "fill_drain");
    smp.delete();
    for (int i = 0; i < 8; i++) smp.push_back(16'h1000 + 16'(i));
    cmp_frames(base, smp, "fill");

    // Acknowledge timeout with busy never rising
    @(posedge clk);
    mode = M_LO;
    base = q.size();
    push1(16'hBEEF);
    k = 0;
    while (k < 20 && !o_tx_start) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_first_start", {31'd0, o_tx_start}, 32'd1);
    s = cyc;
    repeat (15) @(negedge clk);
    chk("tmo_ack_before", {31'd0, o_ack_timeout}, 32'd0);
    @(negedge clk);
    chk("tmo_ack_set", {31'd0, o_ack_timeout}, 32'd1);
    @(negedge clk);
    chk("tmo_next_start", {31'd0, o_tx_start}, 32'd1);
    chk("tmo_next_data", {24'd0, o_tx_data}, 32'hBE);
    chk("tmo_cycle", cyc - s, 32'd17);
    wait_done(base + FL, 300, "tmo_done");
    smp = '{16'hBEEF};
    cmp_frames(base, smp, "tmo");

    // Reset in the middle of the second byte
    @(posedge clk);
    mode = M_AUTO;
    base = q.size();
    push1(16'hCAFE);
    k = 0;
    while (k < 100 && q.size() < base + 2) begin
      @(negedge clk);
      k++;
    end
    chk("mid_second_byte", (q.size() >= base + 2) ? {24'd0, q[base + 1]} : 32'hFFFF_FFFF, 32'hCA);
    repeat (2) @(negedge clk);
    push1(16'h7777);
    chk("mid_level_pre", {27'd0, o_fifo_level}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", {31'd0, o_tx_start}, 32'd0);
    chk("mid_rst_data", {24'd0, o_tx_data}, 32'h00);
    chk("mid_rst_level", {27'd0, o_fifo_level}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_in_ready}, 32'd1);
    chk("mid_rst_ovf", {31'd0, o_overflow}, 32'd0);
    chk("mid_rst_ack", {31'd0, o_ack_timeout}, 32'd0);
    chk("mid_rst_idle", {31'd0, o_idle}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("mid_no_resume", q.size() - base, 32'd2);
    chk("mid_idle_after", {31'd0, o_idle}, 32'd1);

    // Push during pop at level 3, then 20 frames across pointer wrap
    do_reset(M_HI);
    base = q.size();
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back(16'h2000 + 16'(i) * 16'h0111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_in_valid = 1'b1;
      i_in_data = smp[i];
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    @(posedge clk);
    mode = M_AUTO;
    @(negedge clk);
    chk("pp_level_r", {27'd0, o_fifo_level}, 32'd3);
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_data = smp[3];
    chk("pp_level_load", {27'd0, o_fifo_level}, 32'd3);
    @(negedge clk);
    i_in_valid = 1'b0;
    chk("pp_level_after", {27'd0, o_fifo_level}, 32'd3);
    k = 4;
    s = 0;
    while (k < 20 && s < 5000) begin
      @(negedge clk);
      if (o_in_ready) begin
        i_in_valid = 1'b1;
        i_in_data = smp[k];
        k++;
      end else begin
        i_in_valid = 1'b0;
      end
      s++;
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    chk("pp_all_pushed", k, 32'd20);
    wait_done(base + 20 * FL, 4000, "pp_drain");
    cmp_frames(base, smp, "pp");

    chk("start_while_busy", busy_err, 32'd0);
    chk("tx_data_stable", stab_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
